ifid_pipe: RTL and testbench

Parametrised IF/ID pipeline stage with a valid/ready handshake on both sides and a two-entry skid buffer. It carries the fetched instruction and its PC from fetch to decode, supports stall through backpressure and synchronous flush, and presents pre-split instruction fields to decode. It replaces the single-register IF/ID latch and is the template for the later ID/EX and EX/MEM stages.

---
 rtl/mips32_pkg.sv | 31 +++
 rtl/ifid_decode.sv | 34 +++
 rtl/ifid_pipe.sv | 115 +++++++++++
 tb/tb_ifid_pipe.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/mips32_pkg.sv
// Shared MIPS32 instruction-field definitions and the op-key encoding used by
// the IF/ID stage and the later pipeline stages.
package mips32_pkg;

    localparam logic [31:0] NOP_INS_DEF = 32'h0000_0000;

    localparam int OPC_HI   = 31;
    localparam int OPC_LO   = 26;
    localparam int RS_HI    = 25;
    localparam int RS_LO    = 21;
    localparam int RT_HI    = 20;
    localparam int RT_LO    = 16;
    localparam int RD_HI    = 15;
    localparam int RD_LO    = 11;
    localparam int SHAMT_HI = 10;
    localparam int SHAMT_LO = 6;
    localparam int FUNCT_HI = 5;
    localparam int FUNCT_LO = 0;

    localparam int OP_W = 8;

    // R-type instructions are keyed by funct (LSB set), everything else by opcode.
    function automatic logic [OP_W-1:0] op_key(input logic [5:0] opcode,
                                               input logic [5:0] funct);
        if (opcode == 6'd0) begin
            return {1'b0, funct, 1'b1};
        end
        return {1'b0, opcode, 1'b0};
    endfunction

endpackage

// File: rtl/ifid_decode.sv
// Combinational MIPS32 field splitter: turns an instruction word into the
// register indices, immediates and op key consumed by decode.
module ifid_decode
    import mips32_pkg::*;
#(
    parameter int INS_W = 32
) (
    input  logic [INS_W-1:0] ins_i,
    output logic [4:0]       rs_o,
    output logic [4:0]       rt_o,
    output logic [4:0]       rd_o,
    output logic [4:0]       shamt_o,
    output logic [15:0]      imm16_o,
    output logic [31:0]      simm_o,
    output logic [25:0]      imm26_o,
    output logic [OP_W-1:0]  op_o
);

    logic [5:0] opcode;
    logic [5:0] funct;

    assign opcode  = ins_i[OPC_HI:OPC_LO];
    assign funct   = ins_i[FUNCT_HI:FUNCT_LO];

    assign rs_o    = ins_i[RS_HI:RS_LO];
    assign rt_o    = ins_i[RT_HI:RT_LO];
    assign rd_o    = ins_i[RD_HI:RD_LO];
    assign shamt_o = ins_i[SHAMT_HI:SHAMT_LO];
    assign imm16_o = ins_i[15:0];
    assign simm_o  = {{16{ins_i[15]}}, ins_i[15:0]};
    assign imm26_o = ins_i[25:0];
    assign op_o    = op_key(opcode, funct);

endmodule

// File: rtl/ifid_pipe.sv
// IF/ID pipeline stage: valid/ready on both sides with a two-entry skid
// buffer, synchronous flush, and pre-split instruction fields for decode.
module ifid_pipe
    import mips32_pkg::*;
#(
    parameter int              INS_W   = 32,
    parameter int              PC_W    = 32,
    parameter logic [INS_W-1:0] NOP_INS = INS_W'(NOP_INS_DEF)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [INS_W-1:0] i_ins,
    input  logic [PC_W-1:0]  i_pc,
    input  logic             i_flush,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [INS_W-1:0] o_ins,
    output logic [PC_W-1:0]  o_pc,
    output logic [PC_W-1:0]  o_pc4,
    output logic [4:0]       o_rs,
    output logic [4:0]       o_rt,
    output logic [4:0]       o_rd,
    output logic [4:0]       o_shamt,
    output logic [15:0]      o_imm16,
    output logic [31:0]      o_simm,
    output logic [25:0]      o_imm26,
    output logic [OP_W-1:0]  o_op
);

    logic             m_v_q, m_v_d;
    logic [INS_W-1:0] m_ins_q, m_ins_d;
    logic [PC_W-1:0]  m_pc_q, m_pc_d;
    logic             s_v_q, s_v_d;
    logic [INS_W-1:0] s_ins_q, s_ins_d;
    logic [PC_W-1:0]  s_pc_q, s_pc_d;

    logic accept;

    // o_ready comes straight from the skid flag, so it is registered.
    assign o_ready = !s_v_q;
    assign o_valid = m_v_q;
    assign accept  = i_valid && !s_v_q;

    always_comb begin
        m_v_d   = m_v_q;
        m_ins_d = m_ins_q;
        m_pc_d  = m_pc_q;
        s_v_d   = s_v_q;
        s_ins_d = s_ins_q;
        s_pc_d  = s_pc_q;

        if (i_flush) begin
            m_v_d = 1'b0;
            s_v_d = 1'b0;
        end else if (!m_v_q || i_ready) begin
            // Main is free this cycle: the older skid entry goes first.
            if (s_v_q) begin
                m_v_d   = 1'b1;
                m_ins_d = s_ins_q;
                m_pc_d  = s_pc_q;
            end else if (accept) begin
                m_v_d   = 1'b1;
                m_ins_d = i_ins;
                m_pc_d  = i_pc;
            end else begin
                m_v_d = 1'b0;
            end
            s_v_d = 1'b0;
        end else if (accept) begin
            s_v_d   = 1'b1;
            s_ins_d = i_ins;
            s_pc_d  = i_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_v_q   <= 1'b0;
            m_ins_q <= NOP_INS;
            m_pc_q  <= '0;
            s_v_q   <= 1'b0;
            s_ins_q <= NOP_INS;
            s_pc_q  <= '0;
        end else begin
            m_v_q   <= m_v_d;
            m_ins_q <= m_ins_d;
            m_pc_q  <= m_pc_d;
            s_v_q   <= s_v_d;
            s_ins_q <= s_ins_d;
            s_pc_q  <= s_pc_d;
        end
    end

    // Bubbles present NOP_INS / PC 0 so the decoded fields stay well defined.
    assign o_ins = m_v_q ? m_ins_q : NOP_INS;
    assign o_pc  = m_v_q ? m_pc_q  : '0;
    assign o_pc4 = o_pc + PC_W'(4);

    ifid_decode #(
        .INS_W(INS_W)
    ) u_decode (
        .ins_i   (o_ins),
        .rs_o    (o_rs),
        .rt_o    (o_rt),
        .rd_o    (o_rd),
        .shamt_o (o_shamt),
        .imm16_o (o_imm16),
        .simm_o  (o_simm),
        .imm26_o (o_imm26),
        .op_o    (o_op)
    );

endmodule

// File: tb/tb_ifid_pipe.sv
// Scoreboard bench for ifid_pipe: a stimulus process pushes every accepted
// instruction, a negedge monitor compares the presented entry and pops it on consume.
module tb_ifid_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] i_ins;
    logic [31:0] i_pc;
    logic        i_flush;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_ins;
    logic [31:0] o_pc;
    logic [31:0] o_pc4;
    logic [4:0]  o_rs, o_rt, o_rd, o_shamt;
    logic [15:0] o_imm16;
    logic [31:0] o_simm;
    logic [25:0] o_imm26;
    logic [7:0]  o_op;

    int          errors = 0;
    int          checks = 0;
    int          occ = 0;
    logic        mon_en = 1'b0;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    ifid_pipe dut (
        .clk     (clk),
        .rst     (rst),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_ins   (i_ins),
        .i_pc    (i_pc),
        .i_flush (i_flush),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_ins   (o_ins),
        .o_pc    (o_pc),
        .o_pc4   (o_pc4),
        .o_rs    (o_rs),
        .o_rt    (o_rt),
        .o_rd    (o_rd),
        .o_shamt (o_shamt),
        .o_imm16 (o_imm16),
        .o_simm  (o_simm),
        .o_imm26 (o_imm26),
        .o_op    (o_op)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference op key, written from the field definitions with plain arithmetic.
    function automatic logic [31:0] ref_op(input logic [31:0] ins);
        int opcode = int'(ins >> 26);
        int funct  = int'(ins % 64);
        if (opcode == 0) return 32'(funct * 2 + 1);
        return 32'(opcode * 2);
    endfunction

    function automatic logic [31:0] ref_simm(input logic [31:0] ins);
        logic [31:0] imm = ins % 32'h10000;
        if (imm >= 32'h8000) return imm + 32'hFFFF_0000;
        return imm;
    endfunction

    // Monitor: occ is the model's occupancy; a stage of depth two is ready below two.
    always @(negedge clk) begin
        logic [63:0] e;
        logic [31:0] ei, ep;
        if (mon_en && !rst) begin
            chk("o_valid", 32'(o_valid), (occ > 0) ? 32'd1 : 32'd0);
            chk("o_ready", 32'(o_ready), (occ < 2) ? 32'd1 : 32'd0);
            if (occ > 0 && exp_q.size() > 0) begin
                e  = exp_q[0];
                ei = e[63:32];
                ep = e[31:0];
                chk("o_ins",   o_ins, ei);
                chk("o_pc",    o_pc, ep);
                chk("o_pc4",   o_pc4, ep + 32'd4);
                chk("o_rs",    32'(o_rs), (ei >> 21) % 32);
                chk("o_rt",    32'(o_rt), (ei >> 16) % 32);
                chk("o_rd",    32'(o_rd), (ei >> 11) % 32);
                chk("o_shamt", 32'(o_shamt), (ei >> 6) % 32);
                chk("o_imm16", 32'(o_imm16), ei % 32'h10000);
                chk("o_simm",  o_simm, ref_simm(ei));
                chk("o_imm26", 32'(o_imm26), ei % 32'h400_0000);
                chk("o_op",    32'(o_op), ref_op(ei));
                if (i_ready && !i_flush) e = exp_q.pop_front();
            end else if (occ == 0) begin
                chk("bubble_ins", o_ins, 32'h0);
                chk("bubble_pc",  o_pc, 32'h0);
                chk("bubble_pc4", o_pc4, 32'd4);
                chk("bubble_op",  32'(o_op), 32'h01);
            end
        end
    end

    // One cycle of stimulus; expectations are pushed as the input is issued.
    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                         input logic rdy, input logic fl, output logic acc);
        logic cons;
        i_valid = v;
        i_ins   = ins;
        i_pc    = pc;
        i_ready = rdy;
        i_flush = fl;
        acc  = v && (occ < 2) && !fl;
        cons = (occ > 0) && rdy && !fl;
        if (acc) exp_q.push_back({ins, pc});
        @(posedge clk);
        #1;
        if (fl) begin
            exp_q.delete();
            occ = 0;
        end else begin
            occ = occ - (cons ? 1 : 0) + (acc ? 1 : 0);
        end
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        i_valid = 1'b1;
        i_ins   = 32'hDEAD_BEEF;
        i_pc    = 32'h40;
        i_ready = 1'b0;
        i_flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        occ = 0;
    endtask

    initial begin
        logic        acc;
        logic        cur_v;
        logic [31:0] cur_ins, cur_pc;
        logic [31:0] stream[4];

        do_reset();
        mon_en = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, acc);

        // Streaming with the decode examples in the stream.
        stream[0] = 32'h012A_4020;
        stream[1] = 32'h2128_FFFC;
        stream[2] = 32'h0000_0000;
        stream[3] = 32'h8C49_0010;
        for (int i = 0; i < 4; i++) drive(1'b1, stream[i], 32'h100 + 32'(4 * i), 1'b1, 1'b0, acc);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, acc);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, acc);

        // Backpressure: A into main, B into skid, C held by fetch, then drain.
        drive(1'b1, 32'h2108_0001, 32'h200, 1'b0, 1'b0, acc);
        drive(1'b1, 32'h2108_0002, 32'h204, 1'b0, 1'b0, acc);
        for (int i = 0; i < 3; i++) drive(1'b1, 32'h2108_0003, 32'h208, 1'b0, 1'b0, acc);
        drive(1'b1, 32'h2108_0003, 32'h208, 1'b1, 1'b0, acc);
        drive(1'b1, 32'h2108_0003, 32'h208, 1'b1, 1'b0, acc);
        for (int i = 0; i < 3; i++) drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, acc);

        // Flush with both entries full and a third offered.
        drive(1'b1, 32'h0123_0020, 32'h300, 1'b0, 1'b0, acc);
        drive(1'b1, 32'h0123_0022, 32'h304, 1'b0, 1'b0, acc);
        drive(1'b1, 32'h0123_0024, 32'h308, 1'b1, 1'b1, acc);
        drive(1'b1, 32'h3C01_1234, 32'h400, 1'b1, 1'b0, acc);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, acc);

        // PC wrap.
        drive(1'b1, 32'h2128_8000, 32'hFFFF_FFFC, 1'b1, 1'b0, acc);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, acc);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, acc);

        // Reset in the middle of a transfer discards both entries.
        drive(1'b1, 32'h0000_0008, 32'h500, 1'b0, 1'b0, acc);
        drive(1'b1, 32'h0000_000C, 32'h504, 1'b0, 1'b0, acc);
        do_reset();
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, acc);

        // Randomized traffic; fetch holds its offer while it is not taken.
        cur_v   = 1'b0;
        cur_ins = 32'h0;
        cur_pc  = 32'h0;
        acc     = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            logic fl;
            fl = ($urandom_range(0, 31) == 0);
            if (!(cur_v && !acc)) begin
                cur_v   = ($urandom_range(0, 3) != 0);
                cur_ins = $urandom;
                if ($urandom_range(0, 1) == 1) cur_ins = cur_ins % 32'h0400_0000;
                cur_pc  = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            end
            drive(cur_v, cur_ins, cur_pc, ($urandom_range(0, 3) != 0), fl, acc);
            if (fl) acc = 1'b1;
        end

        for (int i = 0; i < 4; i++) drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, acc);
        @(negedge clk);
        #1;
        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
